// File: rtl/id_hazard_ctrl_pkg.sv
// Shared MIPS ID-stage definitions: forwarding select encodings and the
// in-flight register-write scoreboard slot.
package id_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_ID    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       ld;
    } sb_slot_t;

endpackage

// File: rtl/id_hazard_ctrl_slot_match.sv
// Compares one decoded source register against the EX, MEM and WB scoreboard
// slots; $0 never matches.
module hz_slot_match
    import id_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  sb_slot_t   ex_i,
    input  sb_slot_t   mem_i,
    input  sb_slot_t   wb_i,
    output logic       match_ex_o,
    output logic       match_mem_o,
    output logic       match_wb_o,
    output logic       ex_ld_o
);

    logic src_nz;

    always_comb begin
        src_nz      = (src_i != REG_ZERO);
        match_ex_o  = ex_i.v  & (ex_i.dst  == src_i) & src_nz;
        match_mem_o = mem_i.v & (mem_i.dst == src_i) & src_nz;
        match_wb_o  = wb_i.v  & (wb_i.dst  == src_i) & src_nz;
        ex_ld_o     = ex_i.ld;
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// MIPS ID-stage interlock and forwarding controller: scoreboard of in-flight
// writes, stall/flush/bubble generation, EX forward selects, WB bypass, counters.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter bit          FORWARD_EN = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dst,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             wb_bypass_a,
    output logic             wb_bypass_b,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_slot_t ex_q, mem_q, wb_q, ex_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic rs_ex, rs_mem, rs_wb, rs_ex_ld;
    logic rt_ex, rt_mem, rt_wb, rt_ex_ld;
    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic hz, stall, issue;
    logic [1:0] sel_a, sel_b;

    hz_slot_match u_match_rs (
        .src_i       (id_rs),
        .ex_i        (ex_q),
        .mem_i       (mem_q),
        .wb_i        (wb_q),
        .match_ex_o  (rs_ex),
        .match_mem_o (rs_mem),
        .match_wb_o  (rs_wb),
        .ex_ld_o     (rs_ex_ld)
    );

    hz_slot_match u_match_rt (
        .src_i       (id_rt),
        .ex_i        (ex_q),
        .mem_i       (mem_q),
        .wb_i        (wb_q),
        .match_ex_o  (rt_ex),
        .match_mem_o (rt_mem),
        .match_wb_o  (rt_wb),
        .ex_ld_o     (rt_ex_ld)
    );

    always_comb begin
        a_ex  = id_use_rs & rs_ex;
        a_mem = id_use_rs & rs_mem;
        a_wb  = id_use_rs & rs_wb;
        b_ex  = id_use_rt & rt_ex;
        b_mem = id_use_rt & rt_mem;
        b_wb  = id_use_rt & rt_wb;

        if (FORWARD_EN) begin
            hz = id_valid & ((a_ex & rs_ex_ld) | (b_ex & rt_ex_ld));
        end else begin
            hz = id_valid & (a_ex | a_mem | b_ex | b_mem);
        end

        // Redirect wins over a pending stall.
        stall = hz & ~ex_redirect;
        issue = id_valid & ~hz & ~ex_redirect;

        // Slots are empty while in reset, so only the redirect path needs gating.
        stall_pc    = stall;
        stall_ifid  = stall;
        flush_ifid  = ex_redirect & rst;
        bubble_idex = (stall | ex_redirect) & rst;

        wb_bypass_a = id_valid & a_wb & (FORWARD_EN ? ~(a_ex | a_mem) : 1'b1);
        wb_bypass_b = id_valid & b_wb & (FORWARD_EN ? ~(b_ex | b_mem) : 1'b1);
    end

    // Youngest producer wins: EX over MEM.
    always_comb begin
        sel_a = FWD_ID;
        sel_b = FWD_ID;
        if (FORWARD_EN) begin
            if (a_ex) begin
                sel_a = FWD_EXMEM;
            end else if (a_mem) begin
                sel_a = FWD_MEMWB;
            end
            if (b_ex) begin
                sel_b = FWD_EXMEM;
            end else if (b_mem) begin
                sel_b = FWD_MEMWB;
            end
        end
        fwd_a_d = issue ? sel_a : FWD_ID;
        fwd_b_d = issue ? sel_b : FWD_ID;
    end

    always_comb begin
        ex_d.v   = issue & id_reg_write & (id_dst != REG_ZERO);
        ex_d.dst = id_dst;
        ex_d.ld  = id_is_load;

        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_ID;
            fwd_b_q     <= FWD_ID;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Drives a forwarding instance (CNT_W=16) and a non-forwarding instance (CNT_W=4)
// with shared stimulus and compares both against an age-based pipeline model.
module tb_id_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic id_reg_write = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;

    logic [1:0] stall_pc, stall_ifid, flush_ifid, bubble_idex, wb_bypass_a, wb_bypass_b;
    logic [1:0] fwd_a [2];
    logic [1:0] fwd_b [2];
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per instance, destination register by age (0=EX,1=MEM,2=WB), -1 = none.
    int m_dst [2][3];
    bit m_ld  [2][3];
    int m_fa [2];
    int m_fb [2];
    int m_sc [2];
    int m_fc [2];
    int cmax [2] = '{65535, 15};

    always #5 clk = ~clk;

    id_hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_dst(id_dst), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall_pc(stall_pc[0]), .stall_ifid(stall_ifid[0]), .flush_ifid(flush_ifid[0]),
        .bubble_idex(bubble_idex[0]), .wb_bypass_a(wb_bypass_a[0]),
        .wb_bypass_b(wb_bypass_b[0]), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    id_hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_dst(id_dst), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall_pc(stall_pc[1]), .stall_ifid(stall_ifid[1]), .flush_ifid(flush_ifid[1]),
        .bubble_idex(bubble_idex[1]), .wb_bypass_a(wb_bypass_a[1]),
        .wb_bypass_b(wb_bypass_b[1]), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input string s, input int i);
        return $sformatf("%s%0d", s, i);
    endfunction

    // Age of the youngest in-flight writer of r, or 3 if none.
    function automatic int youngest(input int i, input int r);
        if (r == 0) return 3;
        for (int k = 0; k < 3; k++) begin
            if (m_dst[i][k] == r) return k;
        end
        return 3;
    endfunction

    function automatic int obs_sc(input int i);
        return (i == 0) ? int'(sc0) : int'(sc1);
    endfunction

    function automatic int obs_fc(input int i);
        return (i == 0) ? int'(fc0) : int'(fc1);
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit rw, input int dst, input bit ld, input bit rd);
        int a, b;
        bit fe, hz, stl, iss, bpa, bpb;
        @(negedge clk);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_dst = 5'(dst); id_is_load = ld; ex_redirect = rd;
        #1;
        for (int i = 0; i < 2; i++) begin
            fe = (i == 0);
            a  = urs ? youngest(i, rs) : 3;
            b  = urt ? youngest(i, rt) : 3;
            if (fe) hz = v && (a == 0 || b == 0) && m_ld[i][0];
            else    hz = v && (a < 2 || b < 2);
            stl = hz && !rd;
            iss = v && !hz && !rd;
            bpa = v && urs && rs != 0 && (fe ? (a == 2) : (m_dst[i][2] == rs));
            bpb = v && urt && rt != 0 && (fe ? (b == 2) : (m_dst[i][2] == rt));

            check(tg("stall_pc", i),    int'(stall_pc[i]),    int'(stl));
            check(tg("stall_ifid", i),  int'(stall_ifid[i]),  int'(stl));
            check(tg("flush_ifid", i),  int'(flush_ifid[i]),  int'(rd));
            check(tg("bubble_idex", i), int'(bubble_idex[i]), int'(stl || rd));
            check(tg("wb_bypass_a", i), int'(wb_bypass_a[i]), int'(bpa));
            check(tg("wb_bypass_b", i), int'(wb_bypass_b[i]), int'(bpb));
            check(tg("fwd_a", i),       int'(fwd_a[i]),       m_fa[i]);
            check(tg("fwd_b", i),       int'(fwd_b[i]),       m_fb[i]);
            check(tg("stall_cnt", i),   obs_sc(i),            m_sc[i]);
            check(tg("flush_cnt", i),   obs_fc(i),            m_fc[i]);

            m_fa[i] = (iss && fe) ? ((a == 0) ? 1 : (a == 1) ? 2 : 0) : 0;
            m_fb[i] = (iss && fe) ? ((b == 0) ? 1 : (b == 1) ? 2 : 0) : 0;
            m_dst[i][2] = m_dst[i][1]; m_ld[i][2] = m_ld[i][1];
            m_dst[i][1] = m_dst[i][0]; m_ld[i][1] = m_ld[i][0];
            m_dst[i][0] = (iss && rw && dst != 0) ? dst : -1;
            m_ld[i][0]  = ld;
            if (stl && m_sc[i] < cmax[i]) m_sc[i]++;
            if (rd && m_fc[i] < cmax[i]) m_fc[i]++;
        end
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset mid-cycle, checks every output drops at once, releases on a negedge.
    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check(tg("rst_stall_pc", i),    int'(stall_pc[i]),    0);
            check(tg("rst_stall_ifid", i),  int'(stall_ifid[i]),  0);
            check(tg("rst_flush_ifid", i),  int'(flush_ifid[i]),  0);
            check(tg("rst_bubble_idex", i), int'(bubble_idex[i]), 0);
            check(tg("rst_bypass_a", i),    int'(wb_bypass_a[i]), 0);
            check(tg("rst_bypass_b", i),    int'(wb_bypass_b[i]), 0);
            check(tg("rst_fwd_a", i),       int'(fwd_a[i]),       0);
            check(tg("rst_fwd_b", i),       int'(fwd_b[i]),       0);
            check(tg("rst_stall_cnt", i),   obs_sc(i),            0);
            check(tg("rst_flush_cnt", i),   obs_fc(i),            0);
            for (int k = 0; k < 3; k++) begin
                m_dst[i][k] = -1;
                m_ld[i][k]  = 1'b0;
            end
            m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        id_valid = 1'b0; ex_redirect = 1'b0; id_reg_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        pulse_reset();

        // Load-use: lw $8 then add reading $8.
        step(1, 0, 0, 0, 0, 1, 8, 1, 0);
        step(1, 8, 0, 1, 0, 1, 9, 0, 0);
        check("lu_stall", int'(stall_pc[0]), 1);
        step(1, 8, 0, 1, 0, 1, 9, 0, 0);
        check("lu_released", int'(stall_pc[0]), 0);
        nop();
        check("lu_fwd_a", int'(fwd_a[0]), 2);
        check("lu_stall_cnt", int'(sc0), 1);

        // ALU back-to-back, then with one independent instruction between.
        step(1, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 0, 9, 0, 1, 1, 11, 0, 0);
        nop();
        check("alu_d1_fwd_b", int'(fwd_b[0]), 1);
        step(1, 0, 0, 0, 0, 1, 12, 0, 0);
        step(1, 0, 0, 0, 0, 1, 13, 0, 0);
        step(1, 0, 12, 0, 1, 1, 14, 0, 0);
        nop();
        check("alu_d2_fwd_b", int'(fwd_b[0]), 2);

        // WB bypass: producer reaches WB three steps later.
        step(1, 0, 0, 0, 0, 1, 10, 0, 0);
        nop();
        nop();
        step(1, 10, 0, 1, 0, 0, 0, 0, 0);
        check("wb_bypass_a", int'(wb_bypass_a[0]), 1);
        nop();
        check("wb_fwd_a", int'(fwd_a[0]), 0);

        // $0 writer then $0 reader.
        step(1, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 1, 15, 0, 0);
        check("zero_stall", int'(stall_pc[0]), 0);
        check("zero_bypass", int'(wb_bypass_a[0]), 0);

        // Redirect during a load-use stall.
        pulse_reset();
        step(1, 0, 0, 0, 0, 1, 8, 1, 0);
        step(1, 8, 0, 1, 0, 1, 9, 0, 1);
        check("redir_flush", int'(flush_ifid[0]), 1);
        check("redir_stall_pc", int'(stall_pc[0]), 0);
        nop();
        check("redir_flush_cnt", int'(fc0), 1);
        check("redir_stall_cnt", int'(sc0), 0);

        // Async reset in the middle of a stall.
        step(1, 0, 0, 0, 0, 1, 5, 1, 0);
        step(1, 5, 0, 1, 0, 1, 6, 0, 0);
        pulse_reset();

        // Non-forwarding instance: two stall cycles per dependent pair, saturating at 15.
        for (int n = 0; n < 10; n++) begin
            step(1, 0, 0, 0, 0, 1, 20, 0, 0);
            step(1, 20, 0, 1, 0, 1, 21, 0, 0);
            step(1, 20, 0, 1, 0, 1, 21, 0, 0);
        end
        nop();
        check("nf_sat_stall_cnt", int'(sc1), 15);

        // Randomized traffic over a small register window.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(99) < 85), $urandom_range(7), $urandom_range(7),
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(7),
                 ($urandom_range(3) == 0), ($urandom_range(9) == 0));
            if (n % 1000 == 999) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
